// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, ALU operation enum and decoded control bundle.
package riscv_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Word   = 3'b010;
  localparam logic [2:0] F3Jalr   = 3'b000;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Bne    = 3'b001;
  localparam logic [2:0] F3Blt    = 3'b100;
  localparam logic [2:0] F3Bge    = 3'b101;
  localparam logic [2:0] F3Bltu   = 3'b110;
  localparam logic [2:0] F3Bgeu   = 3'b111;
  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Rem    = 3'b110;

  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluSll  = 4'd2,
    AluSlt  = 4'd3,
    AluSltu = 4'd4,
    AluXor  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluOr   = 4'd8,
    AluAnd  = 4'd9,
    AluMul  = 4'd10,
    AluMulh = 4'd11,
    AluDiv  = 4'd12,
    AluRem  = 4'd13
  } alu_op_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    alu_op_e    alu_op;
    logic       alu_src_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } decode_t;

  // alt selects SUB/SRA over ADD/SRL (instr[30] set).
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3AddSub: return alt ? AluSub : AluAdd;
      F3Sll:    return AluSll;
      F3Slt:    return AluSlt;
      F3Sltu:   return AluSltu;
      F3Xor:    return AluXor;
      F3SrlSra: return alt ? AluSra : AluSrl;
      F3Or:     return AluOr;
      default:  return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational I/S/B/J/U immediate extraction, selected by opcode and sign-extended to XLEN.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr_i[6:0])
      OpcOpImm, OpcLoad, OpcJalr: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      OpcStore:  imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OpcBranch: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
      OpcJal:    imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
      OpcLui:    imm32 = {instr_i[31:12], 12'b0};
      default:   imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage with valid/ready handshake and flush; one registered bundle slot.
// Build option: define RV32M_DECODE_EN to decode MUL/MULH/DIV/REM.
module instr_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [XLEN-1:0] o_imm,
  output logic [3:0]      o_alu_op,
  output logic            o_alu_src_imm,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_illegal,
  output logic [31:0]     o_decode_cnt
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  decode_t    dec;
  logic [XLEN-1:0] imm;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (i_instr),
    .imm_o   (imm)
  );

  always_comb begin
    dec        = '0;
    dec.rd     = i_instr[11:7];
    dec.rs1    = i_instr[19:15];
    dec.rs2    = i_instr[24:20];
    dec.alu_op = AluAdd;
    case (opcode)
      OpcOp: begin
        dec.reg_write = 1'b1;
        if (funct7 == F7Base ||
            (funct7 == F7Alt && (funct3 == F3AddSub || funct3 == F3SrlSra))) begin
          dec.alu_op = alu_from_funct3(funct3, funct7 == F7Alt);
        end
`ifdef RV32M_DECODE_EN
        else if (funct7 == F7MulDiv) begin
          case (funct3)
            F3Mul:   dec.alu_op = AluMul;
            F3Mulh:  dec.alu_op = AluMulh;
            F3Div:   dec.alu_op = AluDiv;
            F3Rem:   dec.alu_op = AluRem;
            default: dec.illegal = 1'b1;
          endcase
        end
`endif
        else begin
          dec.illegal = 1'b1;
        end
      end
      OpcOpImm: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        // Shift-immediates carry funct7 in the immediate field; other funct3 take any imm.
        if ((funct3 == F3Sll && funct7 != F7Base) ||
            (funct3 == F3SrlSra && funct7 != F7Base && funct7 != F7Alt)) begin
          dec.illegal = 1'b1;
        end else begin
          dec.alu_op = alu_from_funct3(funct3, funct3 == F3SrlSra && funct7 == F7Alt);
        end
      end
      OpcLoad: begin
        dec.mem_read    = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.illegal     = (funct3 != F3Word);
      end
      OpcStore: begin
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.illegal     = (funct3 != F3Word);
      end
      OpcBranch: begin
        dec.branch = 1'b1;
        case (funct3)
          F3Beq, F3Bne:   dec.alu_op = AluSub;
          F3Blt, F3Bge:   dec.alu_op = AluSlt;
          F3Bltu, F3Bgeu: dec.alu_op = AluSltu;
          default:        dec.illegal = 1'b1;
        endcase
      end
      OpcJal: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OpcJalr: begin
        dec.jump        = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.illegal     = (funct3 != F3Jalr);
      end
      OpcLui: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.rs1         = '0;
      end
      default: dec.illegal = 1'b1;
    endcase

    // Illegal words travel down the pipe inert so execute can trap on them.
    if (dec.illegal) begin
      dec.alu_op      = AluAdd;
      dec.alu_src_imm = 1'b0;
      dec.reg_write   = 1'b0;
      dec.mem_read    = 1'b0;
      dec.mem_write   = 1'b0;
      dec.branch      = 1'b0;
      dec.jump        = 1'b0;
    end
    if (dec.rd == 5'd0) begin
      dec.reg_write = 1'b0;
    end
  end

  logic            valid_q, valid_d;
  decode_t         bundle_q;
  logic [PC_W-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [31:0]     cnt_q;
  logic            capture, fire;

  assign o_ready = !valid_q || i_ready;
  assign capture = i_valid && o_ready && !i_flush;
  assign fire    = valid_q && i_ready && !i_flush;

  always_comb begin
    valid_d = valid_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (capture) begin
        bundle_q <= dec;
        pc_q     <= i_pc;
        imm_q    <= imm;
      end
      if (fire) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign o_valid       = valid_q;
  assign o_pc          = pc_q;
  assign o_imm         = imm_q;
  assign o_rd          = bundle_q.rd;
  assign o_rs1         = bundle_q.rs1;
  assign o_rs2         = bundle_q.rs2;
  assign o_alu_op      = bundle_q.alu_op;
  assign o_alu_src_imm = bundle_q.alu_src_imm;
  assign o_reg_write   = bundle_q.reg_write;
  assign o_mem_read    = bundle_q.mem_read;
  assign o_mem_write   = bundle_q.mem_write;
  assign o_branch      = bundle_q.branch;
  assign o_jump        = bundle_q.jump;
  assign o_illegal     = bundle_q.illegal;
  assign o_decode_cnt  = cnt_q;

endmodule
